// File: rtl/wb_port_arb_pkg.sv
// wb_port_arb_pkg: shared types and defaults for the writeback port arbiter.
package wb_port_arb_pkg;
    typedef logic [4:0] u5;
    typedef logic [63:0] u64;
    typedef struct packed {
        logic valid;
        u5    wd;
        u64   data;
    } wb_req_t;
    typedef enum logic [1:0] {IDLE, WAIT, FORCE} wb_arb_state_t;
    localparam int AGE_MAX_DEF = 4;
endpackage

// File: rtl/wb_aux_buf.sv
// wb_aux_buf: one-entry aux result buffer with saturating age counter.
module wb_aux_buf
    import wb_port_arb_pkg::*;
#(
    parameter int AGE_MAX = AGE_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  u5          in_wd,
    input  u64         in_data,
    input  logic       clear,
    input  logic       age_inc,
    output wb_req_t    entry,
    output logic [2:0] age
);
    localparam logic [2:0] AGE_LAST = 3'(AGE_MAX - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '0;
            age   <= '0;
        end else if (load) begin
            entry <= '{valid: 1'b1, wd: in_wd, data: in_data};
            age   <= '0;
        end else begin
            if (clear) entry.valid <= 1'b0;
            if (age_inc && age != AGE_LAST) age <= age + 3'd1;
        end
    end
endmodule

// File: rtl/wb_port_arb.sv
// wb_port_arb: arbitrates pipeline and aux (mul/div) results onto one regfile write port.
// Optional commit trace outputs enabled by defining WB_PORT_ARB_COMMIT_EN.
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int AGE_MAX = AGE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pipeValid,
    input  u5    pipeWd,
    input  u64   pipeData,
    input  logic auxValid,
    input  u5    auxWd,
    input  u64   auxData,
    output logic auxReady,
    output logic wbEn,
    output u5    wd,
    output u64   wbData,
    output logic stallReq,
`ifdef WB_PORT_ARB_COMMIT_EN
    output logic commitValid,
    output u5    commitWd,
    output u64   commitData,
    output logic commitSrc,
`endif
    output logic errOverrun
);
    localparam logic [2:0] AGE_LAST = 3'(AGE_MAX - 1);
    wb_arb_state_t state, next_state;
    wb_req_t       entry;
    logic [2:0]    age;
    logic          hs, forced, grant_aux, grant_pipe, waw, consume, win_en;
    u5             win_wd;
    u64            win_data;
    assign auxReady = !entry.valid;
    assign stallReq = (state == FORCE);
    always_comb begin
        hs         = auxValid && auxReady;
        forced     = (state == FORCE);
        grant_aux  = forced || (!pipeValid && entry.valid);
        grant_pipe = pipeValid && !forced;
        // A younger pipe write to the same register supersedes the buffered result.
        waw        = grant_pipe && entry.valid && pipeWd != 5'd0 && pipeWd == entry.wd;
        consume    = grant_aux || waw;
        win_wd     = grant_aux ? entry.wd : pipeWd;
        win_data   = grant_aux ? entry.data : pipeData;
        win_en     = (grant_aux || grant_pipe) && win_wd != 5'd0;
        next_state = forced ? IDLE
                   : state == WAIT ? (consume ? IDLE : age == AGE_LAST ? FORCE : WAIT)
                   : (hs ? WAIT : IDLE);
    end
    wb_aux_buf #(.AGE_MAX(AGE_MAX)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (hs),
        .in_wd   (auxWd),
        .in_data (auxData),
        .clear   (consume),
        .age_inc (state == WAIT && !consume),
        .entry   (entry),
        .age     (age)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wbEn       <= 1'b0;
            wd         <= '0;
            wbData     <= '0;
            errOverrun <= 1'b0;
        end else begin
            wbEn <= win_en;
            if (win_en) begin
                wd     <= win_wd;
                wbData <= win_data;
            end
            if (forced && pipeValid) errOverrun <= 1'b1;
        end
    end
`ifdef WB_PORT_ARB_COMMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            commitValid <= 1'b0;
            commitWd    <= '0;
            commitData  <= '0;
            commitSrc   <= 1'b0;
        end else begin
            commitValid <= win_en;
            if (win_en) begin
                commitWd   <= win_wd;
                commitData <= win_data;
                commitSrc  <= grant_aux;
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: directed self-checking bench for wb_port_arb (AGE_MAX = 4).
module tb_wb_port_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipeValid, auxValid, auxReady, wbEn, stallReq, errOverrun;
    logic [4:0]  pipeWd, auxWd, wd;
    logic [63:0] pipeData, auxData, wbData;
`ifdef WB_PORT_ARB_COMMIT_EN
    logic        commitValid, commitSrc;
    logic [4:0]  commitWd;
    logic [63:0] commitData;
`endif
    int n_vec = 0;
    int n_err = 0;

    wb_port_arb #(.AGE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipeValid  (pipeValid),
        .pipeWd     (pipeWd),
        .pipeData   (pipeData),
        .auxValid   (auxValid),
        .auxWd      (auxWd),
        .auxData    (auxData),
        .auxReady   (auxReady),
        .wbEn       (wbEn),
        .wd         (wd),
        .wbData     (wbData),
        .stallReq   (stallReq),
`ifdef WB_PORT_ARB_COMMIT_EN
        .commitValid(commitValid),
        .commitWd   (commitWd),
        .commitData (commitData),
        .commitSrc  (commitSrc),
`endif
        .errOverrun (errOverrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] w, input logic [63:0] d);
        chk({tag, ".wbEn"}, 64'(wbEn), 64'(en));
        if (en) begin
            chk({tag, ".wd"}, 64'(wd), 64'(w));
            chk({tag, ".wbData"}, wbData, d);
        end
    endtask

    initial begin
        rst = 1'b1; pipeValid = 1'b0; pipeWd = '0; pipeData = '0;
        auxValid = 1'b0; auxWd = '0; auxData = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.wbEn", 64'(wbEn), 64'd0);
        chk("rst.wd", 64'(wd), 64'd0);
        chk("rst.wbData", wbData, 64'd0);
        chk("rst.stallReq", 64'(stallReq), 64'd0);
        chk("rst.errOverrun", 64'(errOverrun), 64'd0);
        chk("rst.auxReady", 64'(auxReady), 64'd1);

        // pipe only
        pipeValid = 1'b1; pipeWd = 5'd5; pipeData = 64'hAA;
        tick();
        pipeValid = 1'b0;
        chk_wb("pipe", 1'b1, 5'd5, 64'hAA);
        tick();
        chk_wb("pipe.after", 1'b0, 5'd0, 64'd0);

        // aux on idle port
        auxValid = 1'b1; auxWd = 5'd7; auxData = 64'h1234;
        tick();
        auxValid = 1'b0;
        chk("aux.ready_low", 64'(auxReady), 64'd0);
        chk_wb("aux.t1", 1'b0, 5'd0, 64'd0);
        tick();
        chk_wb("aux.t2", 1'b1, 5'd7, 64'h1234);
        chk("aux.ready_back", 64'(auxReady), 64'd1);
        tick();
        chk_wb("aux.t3", 1'b0, 5'd0, 64'd0);

        // starvation forces a stall after 4 ungranted cycles
        auxValid = 1'b1; auxWd = 5'd3; auxData = 64'h33;
        tick();
        auxValid = 1'b0;
        pipeValid = 1'b1; pipeWd = 5'd10; pipeData = 64'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wb("starve.pipe", 1'b1, 5'd10, 64'h10);
            chk("starve.stallReq", 64'(stallReq), 64'(i == 3));
        end
        pipeValid = 1'b0;
        tick();
        chk_wb("starve.force", 1'b1, 5'd3, 64'h33);
        chk("starve.stall_off", 64'(stallReq), 64'd0);
        chk("starve.errOverrun", 64'(errOverrun), 64'd0);
        chk("starve.auxReady", 64'(auxReady), 64'd1);

        // WAW: younger pipe result wins, buffered entry dropped
        auxValid = 1'b1; auxWd = 5'd9; auxData = 64'h1;
        tick();
        auxValid = 1'b0;
        pipeValid = 1'b1; pipeWd = 5'd9; pipeData = 64'h2;
        tick();
        pipeValid = 1'b0;
        chk_wb("waw", 1'b1, 5'd9, 64'h2);
        chk("waw.auxReady", 64'(auxReady), 64'd1);
        tick();
        chk_wb("waw.no_late1", 1'b0, 5'd0, 64'd0);
        tick();
        chk_wb("waw.no_late2", 1'b0, 5'd0, 64'd0);

        // x0 aux write accepted but not written
        auxValid = 1'b1; auxWd = 5'd0; auxData = 64'h55;
        tick();
        auxValid = 1'b0;
        chk("x0.auxReady_low", 64'(auxReady), 64'd0);
        tick();
        chk_wb("x0.no_write", 1'b0, 5'd0, 64'd0);
        chk("x0.auxReady_back", 64'(auxReady), 64'd1);

        // reset with buffer full drops the entry
        auxValid = 1'b1; auxWd = 5'd4; auxData = 64'h44;
        tick();
        auxValid = 1'b0;
        chk("rstfull.auxReady_low", 64'(auxReady), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_wb("rstfull.no_write", 1'b0, 5'd0, 64'd0);
        chk("rstfull.auxReady", 64'(auxReady), 64'd1);
        tick();
        chk_wb("rstfull.no_late", 1'b0, 5'd0, 64'd0);

        // pipe write during FORCE is dropped and flags overrun
        auxValid = 1'b1; auxWd = 5'd6; auxData = 64'h66;
        tick();
        auxValid = 1'b0;
        pipeValid = 1'b1; pipeWd = 5'd11; pipeData = 64'hBB;
        for (int i = 0; i < 4; i++) tick();
        chk("ovr.stallReq", 64'(stallReq), 64'd1);
        tick();
        pipeValid = 1'b0;
        chk_wb("ovr.aux_wins", 1'b1, 5'd6, 64'h66);
        chk("ovr.errOverrun", 64'(errOverrun), 64'd1);
        tick();
        chk_wb("ovr.idle", 1'b0, 5'd0, 64'd0);
        chk("ovr.sticky", 64'(errOverrun), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovr.cleared", 64'(errOverrun), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_port_arb.md
WB_PORT_ARB -- requirements
Module: wb_port_arb

Interface
REQ-001 SHALL have parameter AGE_MAX, default 4 (range 2..7): cycles a buffered aux result may wait before forcing a pipeline stall.
REQ-002 SHALL have ports, clock and reset first: clk in 1, rising-edge clock.
REQ-003 rst in 1, reset, synchronous, active-high.
REQ-004 pipeValid in 1, writeback stage presents a register write this cycle.
REQ-005 pipeWd in 5, destination register of pipeline write.
REQ-006 pipeData in 64, pipeline write data.
REQ-007 auxValid in 1, multi-cycle unit (mul/div) offers a result.
REQ-008 auxWd in 5 and auxData in 64, aux destination and data.
REQ-009 auxReady out 1, aux result accepted when auxValid&&auxReady at a rising edge.
REQ-010 wbEn out 1, wd out 5, wbData out 64: registered regfile write port.
REQ-011 stallReq out 1, registered; asks the pipeline to freeze writeback.
REQ-012 errOverrun out 1, sticky; pipeline write dropped during forced aux grant.

Function
REQ-013 SHALL hold a one-entry aux buffer (valid, wd, data); auxReady = buffer empty, combinational from state only.
REQ-014 SHALL capture aux result into buffer on handshake; buffer visible to arbitration from the following cycle.
REQ-015 SHALL arbitrate each cycle: FORCE state grants buffer; else pipeValid grants pipe; else full buffer grants aux; else no grant.
REQ-016 SHALL register the grant: wbEn/wd/wbData reflect the winner one cycle after request (latency 1); wbEn=0 otherwise.
REQ-017 SHALL suppress writes to x0: a granted request with wd=0 yields wbEn=0 and still counts as consumed.
REQ-018 SHALL empty the buffer in the cycle its entry is granted; a new aux handshake can complete the following cycle (no same-cycle refill).
REQ-019 SHALL discard the buffered entry, without writing, when a granted pipe write has the same nonzero wd (younger result wins, WAW).
REQ-020 SHALL run FSM IDLE (buffer empty), WAIT (buffer full, not granted), FORCE (stallReq=1).
REQ-021 Transitions: IDLE->WAIT on handshake; WAIT->IDLE when granted or discarded; WAIT->FORCE when age counter reaches AGE_MAX-1 ungranted; FORCE->IDLE after exactly one cycle (buffer granted).
REQ-022 SHALL clear the 3-bit age counter on entering WAIT, increment each ungranted WAIT cycle, saturate at AGE_MAX-1.
REQ-023 stallReq SHALL be 1 exactly in FORCE; pipeline guarantees pipeValid=0 in that cycle; if pipeValid=1, pipe request is dropped and errOverrun set until reset.
REQ-024 Simultaneous handshake and grant of old entry cannot occur (REQ-018); simultaneous pipe and buffer requests resolve per REQ-015/REQ-019.

Reset
REQ-025 On rst at a rising edge: wbEn=0, wd=0, wbData=0, stallReq=0, errOverrun=0, buffer empty, age=0, state IDLE, auxReady=1 the following cycle.
REQ-026 Reset mid-operation SHALL drop any buffered result with no write; rst has priority over all inputs.

Configuration
REQ-027 With WB_PORT_ARB_COMMIT_EN defined: SHALL add outputs commitValid 1, commitWd 5, commitData 64, commitSrc 1 (0 pipe, 1 aux), registered, valid exactly when wbEn=1, same cycle and values; reset 0.
REQ-028 Without WB_PORT_ARB_COMMIT_EN: commit ports absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold u5/u64, WB_REQ struct (valid, wd, data), WB_ARB_STATE enum, and the default AGE_MAX constant.
REQ-030 Buffer plus age counter SHALL be sub-module wb_aux_buf; arbitration and FSM in top.

Verification
REQ-031 Pipe only: pipeValid=1, pipeWd=5, pipeData=0xAA for one cycle -> next cycle wbEn=1, wd=5, wbData=0xAA; then wbEn=0.
REQ-032 Aux idle port: auxValid=1, auxWd=7, auxData=0x1234 at cycle t -> auxReady=0 at t+1, wbEn=1/wd=7/wbData=0x1234 at t+2, auxReady=1 at t+2.
REQ-033 Starvation: buffer holds wd=3, pipeValid=1 continuously -> after AGE_MAX ungranted cycles stallReq=1 for one cycle, drive pipeValid=0 then; next cycle wd=3 written, stallReq=0, errOverrun=0.
REQ-034 WAW: buffer wd=9 data 0x1, pipe wd=9 data 0x2 -> single write wd=9 wbData=0x2; buffer empty, no later write.
REQ-035 x0 and reset: aux wd=0 -> accepted, wbEn stays 0; rst asserted while buffer full -> no write, auxReady=1 after reset; pipeValid=1 during FORCE -> errOverrun=1 and stays 1.
